// File: rtl/mem_access_ctrl_if.sv
// Requester and memory-side bus of the unified memory access controller.
// The slave modport is the controller; the master modport is its environment.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_done;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_done;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mdr;
   logic              err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, mem_addr, mem_wdata, mdr, err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, mem_addr, mem_wdata, mdr, err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates IF/DM onto one memory port (DM priority); registered outputs, req->done >= 2 cycles.
// Requesters hold req until done; memory stalls via mem_ready, hung accesses abort after WAIT_MAX cycles.
module mem_access_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(WAIT_MAX - 1);

   state_t            state, state_nxt;
   logic              owner_dm, owner_dm_nxt;
   logic [7:0]        wait_cnt, wait_cnt_nxt;
   logic              we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [DATA_W-1:0] mdr_nxt;
   logic              err_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner_dm <= 1'b0;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         owner_dm <= owner_dm_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_dm_nxt = owner_dm;
      wait_cnt_nxt = wait_cnt;
      we_nxt       = bus.mem_we;
      addr_nxt     = bus.mem_addr;
      wdata_nxt    = bus.mem_wdata;
      mdr_nxt      = bus.mdr;
      err_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.dm_req) begin
               state_nxt    = ACCESS;
               owner_dm_nxt = 1'b1;
               we_nxt       = bus.dm_we;
               addr_nxt     = bus.dm_addr;
               wdata_nxt    = bus.dm_wdata;
            end else if (bus.if_req) begin
               state_nxt    = ACCESS;
               owner_dm_nxt = 1'b0;
               we_nxt       = 1'b0;
               addr_nxt     = bus.if_addr;
               wdata_nxt    = '0;
            end
         end
         ACCESS: begin
            // completion on the timeout edge still counts as a normal completion
            if (bus.mem_ready) begin
               state_nxt = RESP;
               if (!bus.mem_we) mdr_nxt = bus.mem_rdata;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
               if (wait_cnt == LAST_WAIT) begin
                  state_nxt = RESP;
                  err_nxt   = 1'b1;
               end
            end
         end
         RESP: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = 8'd0;
         end
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   // outputs are decoded from the next state so they register alongside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mdr       <= '0;
         bus.err       <= 1'b0;
         bus.if_gnt    <= 1'b0;
         bus.dm_gnt    <= 1'b0;
         bus.if_done   <= 1'b0;
         bus.dm_done   <= 1'b0;
      end else begin
         bus.mem_en    <= (state_nxt == ACCESS);
         bus.mem_we    <= we_nxt;
         bus.mem_addr  <= addr_nxt;
         bus.mem_wdata <= wdata_nxt;
         bus.mdr       <= mdr_nxt;
         bus.err       <= err_nxt;
         bus.if_gnt    <= (state_nxt == ACCESS) && !owner_dm_nxt;
         bus.dm_gnt    <= (state_nxt == ACCESS) &&  owner_dm_nxt;
         bus.if_done   <= (state_nxt == RESP)   && !owner_dm_nxt;
         bus.dm_done   <= (state_nxt == RESP)   &&  owner_dm_nxt;
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_mem_access_ctrl;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int WAIT_MAX = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic clear_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] outs;
      clear_inputs();
      rst_n = 1'b0;
      #12;
      outs = {bus.if_gnt, bus.if_done, bus.dm_gnt, bus.dm_done, bus.mem_en,
              bus.mem_we, bus.err, 3'b000};
      total++;
      if (outs !== 10'd0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0", outs);
      end
      total++;
      if ({bus.mdr, bus.mem_addr, bus.mem_wdata} !== 96'd0) begin
         bad++; $display("FAIL reset_data mdr=%h addr=%h wdata=%h exp=0", bus.mdr, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch_read();
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      @(negedge clk);
      total++;
      if ({bus.mem_en, bus.if_gnt, bus.dm_gnt, bus.mem_we} !== 4'b1100 || bus.mem_addr !== 32'h10) begin
         bad++; $display("FAIL fetch_cycle1 en/ig/dg/we=%b addr=%h exp=1100 addr=10",
                         {bus.mem_en, bus.if_gnt, bus.dm_gnt, bus.mem_we}, bus.mem_addr);
      end
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'd34;
      total++;
      if ({bus.mem_en, bus.if_gnt, bus.if_done} !== 3'b110) begin
         bad++; $display("FAIL fetch_cycle2 en/gnt/done=%b exp=110", {bus.mem_en, bus.if_gnt, bus.if_done});
      end
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.if_req = 1'b0;
      total++;
      if ({bus.if_done, bus.dm_done, bus.err, bus.if_gnt, bus.mem_en} !== 5'b10000 || bus.mdr !== 32'd34) begin
         bad++; $display("FAIL fetch_done idone/ddone/err/gnt/en=%b mdr=%0d exp=10000 mdr=34",
                         {bus.if_done, bus.dm_done, bus.err, bus.if_gnt, bus.mem_en}, bus.mdr);
      end
      @(negedge clk);
      total++;
      if ({bus.if_done, bus.mem_en} !== 2'b00) begin
         bad++; $display("FAIL fetch_pulse done/en=%b exp=00", {bus.if_done, bus.mem_en});
      end
   endtask

   task automatic test_store();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234;
      total++;
      if ({bus.mem_en, bus.dm_gnt, bus.if_gnt, bus.mem_we} !== 4'b1101 ||
          bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL store_access en/dg/ig/we=%b addr=%h wdata=%h exp=1101 40 deadbeef",
                         {bus.mem_en, bus.dm_gnt, bus.if_gnt, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      total++;
      if ({bus.dm_done, bus.if_done, bus.err} !== 3'b100 || bus.mdr !== 32'd34) begin
         bad++; $display("FAIL store_done dd/id/err=%b mdr=%0d exp=100 mdr=34",
                         {bus.dm_done, bus.if_done, bus.err}, bus.mdr);
      end
      @(negedge clk);
   endtask

   task automatic test_simultaneous();
      bus.if_req = 1'b1; bus.if_addr = 32'h20;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h44;
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'd5;
      total++;
      if ({bus.dm_gnt, bus.if_gnt} !== 2'b10 || bus.mem_addr !== 32'h44) begin
         bad++; $display("FAIL simul_dm_first dg/ig=%b addr=%h exp=10 addr=44", {bus.dm_gnt, bus.if_gnt}, bus.mem_addr);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.dm_req = 1'b0;
      total++;
      if ({bus.dm_done, bus.if_done} !== 2'b10 || bus.mdr !== 32'd5) begin
         bad++; $display("FAIL simul_dm_done dd/id=%b mdr=%0d exp=10 mdr=5", {bus.dm_done, bus.if_done}, bus.mdr);
      end
      @(negedge clk);
      total++;
      if ({bus.mem_en, bus.if_gnt} !== 2'b00) begin
         bad++; $display("FAIL simul_idle_gap en/ig=%b exp=00", {bus.mem_en, bus.if_gnt});
      end
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'd77;
      total++;
      if ({bus.if_gnt, bus.dm_gnt} !== 2'b10 || bus.mem_addr !== 32'h20 || bus.mem_we !== 1'b0) begin
         bad++; $display("FAIL simul_if_second ig/dg=%b addr=%h we=%b exp=10 addr=20 we=0",
                         {bus.if_gnt, bus.dm_gnt}, bus.mem_addr, bus.mem_we);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.if_req = 1'b0;
      total++;
      if ({bus.if_done, bus.dm_done} !== 2'b10 || bus.mdr !== 32'd77) begin
         bad++; $display("FAIL simul_if_done id/dd=%b mdr=%0d exp=10 mdr=77", {bus.if_done, bus.dm_done}, bus.mdr);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int en_cnt = 0;
      int done_cyc = 0;
      logic err_at_done = 1'b0;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h80; bus.mem_rdata = 32'hBAD0BAD0;
      for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         if (bus.mem_en) en_cnt++;
         if (bus.dm_done) begin
            done_cyc = cyc; err_at_done = bus.err;
         end
      end
      bus.dm_req = 1'b0;
      total++;
      if (done_cyc != WAIT_MAX + 1) begin
         bad++; $display("FAIL timeout_latency done_cycle=%0d exp=%0d", done_cyc, WAIT_MAX + 1);
      end
      total++;
      if (en_cnt != WAIT_MAX) begin
         bad++; $display("FAIL timeout_en_cycles got=%0d exp=%0d", en_cnt, WAIT_MAX);
      end
      total++;
      if (err_at_done !== 1'b1 || bus.mdr !== 32'd77) begin
         bad++; $display("FAIL timeout_err err=%b mdr=%0d exp=1 mdr=77", err_at_done, bus.mdr);
      end
      @(negedge clk);
      total++;
      if ({bus.err, bus.dm_done} !== 2'b00) begin
         bad++; $display("FAIL timeout_err_pulse err/done=%b exp=00", {bus.err, bus.dm_done});
      end
      bus.if_req = 1'b1; bus.if_addr = 32'h30;
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.if_req = 1'b0;
      total++;
      if ({bus.if_done, bus.err} !== 2'b10 || bus.mdr !== 32'h99) begin
         bad++; $display("FAIL timeout_recover done/err=%b mdr=%h exp=10 mdr=99", {bus.if_done, bus.err}, bus.mdr);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout_boundary();
      int en_cnt = 0;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h84;
      for (int i = 1; i <= WAIT_MAX; i++) begin
         @(negedge clk);
         if (bus.mem_en && !bus.dm_done) en_cnt++;
         if (i == WAIT_MAX) begin
            bus.mem_ready = 1'b1; bus.mem_rdata = 32'hABCD;
         end
      end
      total++;
      if (en_cnt != WAIT_MAX) begin
         bad++; $display("FAIL boundary_en_cycles got=%0d exp=%0d", en_cnt, WAIT_MAX);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.dm_req = 1'b0;
      total++;
      if ({bus.dm_done, bus.err} !== 2'b10 || bus.mdr !== 32'hABCD) begin
         bad++; $display("FAIL boundary_done done/err=%b mdr=%h exp=10 mdr=abcd", {bus.dm_done, bus.err}, bus.mdr);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      int done_seen = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h50;
      @(negedge clk);
      total++;
      if ({bus.mem_en, bus.if_gnt} !== 2'b11) begin
         bad++; $display("FAIL midrst_pre en/gnt=%b exp=11", {bus.mem_en, bus.if_gnt});
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.mem_en, bus.if_gnt, bus.dm_gnt} !== 3'b000 || bus.mdr !== 32'd0) begin
         bad++; $display("FAIL midrst_async en/ig/dg=%b mdr=%h exp=000 mdr=0",
                         {bus.mem_en, bus.if_gnt, bus.dm_gnt}, bus.mdr);
      end
      bus.if_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.if_done || bus.dm_done || bus.mem_en) done_seen++;
      end
      total++;
      if (done_seen != 0) begin
         bad++; $display("FAIL midrst_after activity_cycles=%0d exp=0", done_seen);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_read();
      test_store();
      test_simultaneous();
      test_timeout();
      test_timeout_boundary();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
